// File: rtl/rvga_types.sv
// rtl/rvga_types.sv - shared pipeline types: control word, funct3 load/store encodings, MEM FSM states
package rvga_types;

  localparam int CW_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic               valid;
    logic               is_load;
    logic               is_store;
    logic [2:0]         funct3;
    logic [CW_XLEN-1:0] alu_result;
    logic [CW_XLEN-1:0] rs2_data;
    logic [4:0]         rd;
    logic               rd_we;
    logic [CW_XLEN-1:0] rd_data;
  } rvga_cword;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_e;

  // funct3[1:0] carries the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the byte/halfword lane of a load word and applies sign/zero extension
module load_align
  import rvga_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_LH:   data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_b};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - MEM stage: data-memory request FSM, store lane steering, load alignment
module memory_access
  import rvga_types::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  rvga_cword       ex_mem_cword,
  output rvga_cword       mem_wb_cword,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [BE_W-1:0] dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            misalign_exc
);

  mem_state_e      state_q, state_d;
  rvga_cword       cw_q, wb_d;
  logic [XLEN-1:0] addr_q, wdata_q, wdata_d, lbuf_q, load_val;
  logic [BE_W-1:0] be_q, be_d;
  logic            we_q;
  logic            is_mem, misaligned, go;

  assign is_mem     = ex_mem_cword.valid & (ex_mem_cword.is_load | ex_mem_cword.is_store);
  assign misaligned = is_mem & is_misaligned(ex_mem_cword.funct3, ex_mem_cword.alu_result[1:0]);
  assign go         = is_mem & ~misaligned;

  // Sub-word stores replicate the data so the byte enables alone pick the lane
  always_comb begin
    case (ex_mem_cword.funct3[1:0])
      2'b00: begin
        be_d    = BE_W'(1) << ex_mem_cword.alu_result[1:0];
        wdata_d = {(XLEN/8){ex_mem_cword.rs2_data[7:0]}};
      end
      2'b01: begin
        be_d    = BE_W'(3) << ex_mem_cword.alu_result[1:0];
        wdata_d = {(XLEN/16){ex_mem_cword.rs2_data[15:0]}};
      end
      default: begin
        be_d    = '1;
        wdata_d = ex_mem_cword.rs2_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = BUSY;
      BUSY:    if (dmem_ack) state_d = DONE;
      DONE:    if (!stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_be      = '0;
    mem_stall    = 1'b0;
    misalign_exc = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          mem_stall    = go;
          misalign_exc = misaligned & ~stall;
        end
        BUSY: begin
          dmem_req  = 1'b1;
          dmem_we   = we_q;
          dmem_be   = be_q;
          mem_stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3  (cw_q.funct3),
    .addr_lo (addr_q[1:0]),
    .rdata   (lbuf_q),
    .data    (load_val)
  );

  always_comb begin
    wb_d = ex_mem_cword;
    case (state_q)
      IDLE: begin
        if (go)              wb_d = '0;
        else if (misaligned) wb_d.rd_we = 1'b0;
      end
      DONE: begin
        wb_d = cw_q;
        if (cw_q.is_store) wb_d.rd_we   = 1'b0;
        if (cw_q.is_load)  wb_d.rd_data = load_val;
      end
      default: wb_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cw_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      lbuf_q       <= '0;
      mem_wb_cword <= '0;
    end else begin
      if (state_q == IDLE && go) begin
        cw_q    <= ex_mem_cword;
        addr_q  <= ex_mem_cword.alu_result;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        we_q    <= ex_mem_cword.is_store;
      end
      if (state_q == BUSY && dmem_ack) lbuf_q <= dmem_rdata;
      if (!stall) mem_wb_cword <= wb_d;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed vector bench for memory_access
module tb_memory_access;
  import rvga_types::*;

  logic        clk, rst_n, stall;
  rvga_cword   ex_mem_cword, mem_wb_cword;
  logic        mem_stall, dmem_req, dmem_we, dmem_ack, misalign_exc;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int n_tests = 0;
  int n_fail  = 0;

  memory_access #(.XLEN(32), .BE_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .ex_mem_cword (ex_mem_cword),
    .mem_wb_cword (mem_wb_cword),
    .mem_stall    (mem_stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .misalign_exc (misalign_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_data;
    int          lat;
    logic [31:0] e_rd_data;
    logic        e_rd_we;
    int          e_stall;
    logic        e_req;
    logic        e_exc;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic rvga_cword mk_cw(input logic ld, input logic st, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] rs2,
                                      input logic [4:0] rd, input logic we, input logic [31:0] rdd);
    rvga_cword c;
    c            = '0;
    c.valid      = 1'b1;
    c.is_load    = ld;
    c.is_store   = st;
    c.funct3     = f3;
    c.alu_result = a;
    c.rs2_data   = rs2;
    c.rd         = rd;
    c.rd_we      = we;
    c.rd_data    = rdd;
    return c;
  endfunction

  // Drives one cword until it retires; acks after lat extra BUSY cycles
  task automatic run_op(input rvga_cword c, input logic [31:0] rdata, input int lat,
                        output rvga_cword wb, output int nst, output logic req, output logic exc,
                        output logic [3:0] be, output logic [31:0] wd, output logic we);
    int busy;
    bit done;
    busy = 0; done = 0; nst = 0; req = 1'b0; exc = 1'b0;
    be = 4'h0; wd = 32'h0; we = 1'b0; wb = '0;
    ex_mem_cword = c;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (mem_stall) nst++;
      if (misalign_exc) exc = 1'b1;
      if (dmem_req) begin
        req = 1'b1;
        busy++;
        be = dmem_be;
        wd = dmem_wdata;
        we = dmem_we;
        dmem_rdata = rdata;
        dmem_ack = (busy > lat);
      end
      done = !mem_stall;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
    end
    if (!done) chk("op_timeout", 32'd0, 32'd1);
    wb = mem_wb_cword;
    ex_mem_cword = '0;
  endtask

  rvga_cword c, wb;
  int        nst;
  logic      req, exc, we;
  logic [3:0] be;
  logic [31:0] wd;

  initial begin
    //          name   ld    st    f3      addr        rs2           rdata         rd     rdwe  rd_data      lat | e_rd_data   e_we  st  req   exc   be     wdata         we
    vecs[0]  = '{"lw",    1'b1, 1'b0, F3_LW,  32'h100, 32'h0,        32'hDEADBEEF, 5'd5,  1'b1, 32'h0,       0, 32'hDEADBEEF, 1'b1, 2, 1'b1, 1'b0, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{"lb",    1'b1, 1'b0, F3_LB,  32'h103, 32'h0,        32'h80112233, 5'd6,  1'b1, 32'h0,       0, 32'hFFFFFF80, 1'b1, 2, 1'b1, 1'b0, 4'h8, 32'h0,        1'b0};
    vecs[2]  = '{"lbu",   1'b1, 1'b0, F3_LBU, 32'h103, 32'h0,        32'h80112233, 5'd6,  1'b1, 32'h0,       1, 32'h00000080, 1'b1, 3, 1'b1, 1'b0, 4'h8, 32'h0,        1'b0};
    vecs[3]  = '{"sh",    1'b0, 1'b1, F3_SH,  32'h202, 32'h0000ABCD, 32'h0,        5'd0,  1'b1, 32'h55,      0, 32'h00000055, 1'b0, 2, 1'b1, 1'b0, 4'hC, 32'hABCDABCD, 1'b1};
    vecs[4]  = '{"lw_mis",1'b1, 1'b0, F3_LW,  32'h101, 32'h0,        32'h0,        5'd7,  1'b1, 32'h77,      0, 32'h00000077, 1'b0, 0, 1'b0, 1'b1, 4'h0, 32'h0,        1'b0};
    vecs[5]  = '{"lh",    1'b1, 1'b0, F3_LH,  32'h102, 32'h0,        32'h80017FFF, 5'd8,  1'b1, 32'h0,       0, 32'hFFFF8001, 1'b1, 2, 1'b1, 1'b0, 4'hC, 32'h0,        1'b0};
    vecs[6]  = '{"lhu",   1'b1, 1'b0, F3_LHU, 32'h100, 32'h0,        32'h1234F00D, 5'd9,  1'b1, 32'h0,       2, 32'h0000F00D, 1'b1, 4, 1'b1, 1'b0, 4'h3, 32'h0,        1'b0};
    vecs[7]  = '{"sb",    1'b0, 1'b1, F3_SB,  32'h101, 32'h123456A5, 32'h0,        5'd3,  1'b1, 32'h99,      0, 32'h00000099, 1'b0, 2, 1'b1, 1'b0, 4'h2, 32'hA5A5A5A5, 1'b1};
    vecs[8]  = '{"sw",    1'b0, 1'b1, F3_SW,  32'h204, 32'hCAFEF00D, 32'h0,        5'd0,  1'b0, 32'h0,       3, 32'h00000000, 1'b0, 5, 1'b1, 1'b0, 4'hF, 32'hCAFEF00D, 1'b1};
    vecs[9]  = '{"alu",   1'b0, 1'b0, F3_LB,  32'h3,   32'h0,        32'h0,        5'd10, 1'b1, 32'h1234,    0, 32'h00001234, 1'b1, 0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0};
    vecs[10] = '{"lhu_mis",1'b1,1'b0, F3_LHU, 32'h103, 32'h0,        32'h0,        5'd11, 1'b1, 32'h42,      0, 32'h00000042, 1'b0, 0, 1'b0, 1'b1, 4'h0, 32'h0,        1'b0};
    vecs[11] = '{"lw_rd0",1'b1, 1'b0, F3_LW,  32'h108, 32'h0,        32'h0BADF00D, 5'd0,  1'b1, 32'h0,       0, 32'h0BADF00D, 1'b1, 2, 1'b1, 1'b0, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{"sw_mis",1'b0, 1'b1, F3_SW,  32'h206, 32'h1,        32'h0,        5'd0,  1'b0, 32'h3,       0, 32'h00000003, 1'b0, 0, 1'b0, 1'b1, 4'h0, 32'h0,        1'b0};
    vecs[13] = '{"sb0",   1'b0, 1'b1, F3_SB,  32'h100, 32'hFF,       32'h0,        5'd0,  1'b0, 32'h0,       0, 32'h00000000, 1'b0, 2, 1'b1, 1'b0, 4'h1, 32'hFFFFFFFF, 1'b1};

    // Reset: outputs gated low even with memory ops presented
    rst_n = 1'b0; stall = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    ex_mem_cword = mk_cw(1'b1, 1'b0, F3_LW, 32'h101, 32'h0, 5'd1, 1'b1, 32'h0);
    @(negedge clk);
    chk("rst_misalign", 32'(misalign_exc), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    ex_mem_cword = mk_cw(1'b1, 1'b0, F3_LW, 32'h100, 32'h0, 5'd1, 1'b1, 32'h0);
    @(negedge clk);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    @(posedge clk); #1;
    chk("rst_wb_zero", 32'(mem_wb_cword == '0), 32'd1);
    ex_mem_cword = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      c = mk_cw(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].rs2,
                vecs[i].rd, vecs[i].rd_we, vecs[i].rd_data);
      run_op(c, vecs[i].rdata, vecs[i].lat, wb, nst, req, exc, be, wd, we);
      chk({vecs[i].name, "_rd_data"}, wb.rd_data, vecs[i].e_rd_data);
      chk({vecs[i].name, "_rd_we"}, 32'(wb.rd_we), 32'(vecs[i].e_rd_we));
      chk({vecs[i].name, "_valid"}, 32'(wb.valid), 32'd1);
      chk({vecs[i].name, "_rd"}, 32'(wb.rd), 32'(vecs[i].rd));
      chk({vecs[i].name, "_stall_cycles"}, 32'(nst), 32'(vecs[i].e_stall));
      chk({vecs[i].name, "_req"}, 32'(req), 32'(vecs[i].e_req));
      chk({vecs[i].name, "_exc"}, 32'(exc), 32'(vecs[i].e_exc));
      chk({vecs[i].name, "_be"}, 32'(be), 32'(vecs[i].e_be));
      chk({vecs[i].name, "_wdata"}, wd, vecs[i].e_wdata);
      chk({vecs[i].name, "_we"}, 32'(we), 32'(vecs[i].e_we));
    end

    // Late ack with downstream stall on the ack cycle for 3 cycles
    ex_mem_cword = mk_cw(1'b1, 1'b0, F3_LW, 32'h100, 32'h0, 5'd2, 1'b1, 32'h0);
    dmem_rdata = 32'hA5A50001;
    @(negedge clk);
    chk("b_idle_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_req", 32'(dmem_req), 32'd1);
      chk("b_addr", dmem_addr, 32'h100);
      chk("b_be", 32'(dmem_be), 32'hF);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("b_req_ack", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1;
    stall = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("b_done_mem_stall", 32'(mem_stall), 32'd0);
    chk("b_done_req", 32'(dmem_req), 32'd0);
    chk("b_hold1", 32'(mem_wb_cword == '0), 32'd1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("b_hold2", 32'(mem_wb_cword == '0), 32'd1);
    @(posedge clk); #1;
    stall = 1'b0;
    @(negedge clk);
    chk("b_hold3", 32'(mem_wb_cword == '0), 32'd1);
    @(posedge clk); #1;
    ex_mem_cword = '0;
    chk("b_rd_data", mem_wb_cword.rd_data, 32'hA5A50001);
    chk("b_valid", 32'(mem_wb_cword.valid), 32'd1);
    chk("b_rd_we", 32'(mem_wb_cword.rd_we), 32'd1);
    @(posedge clk); #1;
    chk("b_emit_once", 32'(mem_wb_cword.valid), 32'd0);

    // Reset in the second BUSY cycle, then a stray ack
    ex_mem_cword = mk_cw(1'b1, 1'b0, F3_LW, 32'h100, 32'h0, 5'd4, 1'b1, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ex_mem_cword = '0;
    @(negedge clk);
    chk("c_req_dropped", 32'(dmem_req), 32'd0);
    chk("c_wb_zero", 32'(mem_wb_cword == '0), 32'd1);
    chk("c_mem_stall", 32'(mem_stall), 32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("c_no_retry", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
    end
    chk("c_wb_invalid", 32'(mem_wb_cword.valid), 32'd0);

    // Global stall holds a pass-through op, then a stalled misaligned store
    ex_mem_cword = mk_cw(1'b0, 1'b0, F3_LB, 32'h0, 32'h0, 5'd12, 1'b1, 32'h1111);
    stall = 1'b1;
    @(posedge clk); #1;
    chk("d_hold", 32'(mem_wb_cword.valid), 32'd0);
    stall = 1'b0;
    @(posedge clk); #1;
    chk("d_pass", mem_wb_cword.rd_data, 32'h1111);
    ex_mem_cword = mk_cw(1'b0, 1'b1, F3_SW, 32'h2, 32'h0, 5'd13, 1'b1, 32'h2222);
    stall = 1'b1;
    @(negedge clk);
    chk("d_exc_stalled", 32'(misalign_exc), 32'd0);
    @(posedge clk); #1;
    chk("d_hold2", mem_wb_cword.rd_data, 32'h1111);
    stall = 1'b0;
    @(negedge clk);
    chk("d_exc", 32'(misalign_exc), 32'd1);
    chk("d_no_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    ex_mem_cword = '0;
    chk("d_mis_rd_data", mem_wb_cword.rd_data, 32'h2222);
    chk("d_mis_rd_we", 32'(mem_wb_cword.rd_we), 32'd0);
    @(negedge clk);
    chk("d_exc_pulse", 32'(misalign_exc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data and address width.
REQ-002 The block SHALL have parameter BE_W, default XLEN/8, giving the byte-enable width.
REQ-003 The block SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port stall  in  1  global pipeline stall from hazard control.
REQ-006 The block SHALL have port ex_mem_cword  in  rvga_cword  control word from execute; fields used: valid, is_load, is_store, funct3, alu_result (address), rs2_data, rd, rd_we, rd_data.
REQ-007 The block SHALL have port mem_wb_cword  out  rvga_cword  registered control word to writeback.
REQ-008 The block SHALL have port mem_stall  out  1  request for upstream stages to hold while an access is outstanding.
REQ-009 The block SHALL have ports dmem_req  out  1, dmem_we  out  1, dmem_addr  out  XLEN, dmem_wdata  out  XLEN and dmem_be  out  BE_W, forming the data-memory request.
REQ-010 The block SHALL have ports dmem_ack  in  1, completing the request, and dmem_rdata  in  XLEN, valid with dmem_ack.
REQ-011 The block SHALL have port misalign_exc  out  1  one-cycle pulse on a misaligned access.

Function
REQ-012 The FSM SHALL use three states: IDLE, BUSY, DONE.
REQ-013 In IDLE, a valid aligned load/store on ex_mem_cword SHALL move the FSM to BUSY on the next edge and latch address, write data, byte enables and the cword.
REQ-014 In BUSY, dmem_req SHALL be 1 and dmem_addr/dmem_wdata/dmem_be/dmem_we SHALL be held stable until the cycle dmem_ack=1.
REQ-015 On dmem_ack in BUSY, the FSM SHALL capture dmem_rdata into a load buffer and move to DONE; a single-cycle ack SHALL give a minimum stage latency of 2 cycles.
REQ-016 dmem_ack SHALL be ignored in IDLE and DONE.
REQ-017 In DONE, when stall=0, the FSM SHALL write the completed cword to mem_wb_cword and return to IDLE; when stall=1 it SHALL remain in DONE with the buffer held.
REQ-018 mem_stall SHALL be 1 in BUSY, and SHALL be 1 combinationally in IDLE while a valid aligned memory op is present.
REQ-019 mem_stall SHALL be 0 in DONE and for non-memory ops.
REQ-020 Non-memory valid cwords SHALL pass to mem_wb_cword with 1-cycle latency when stall=0.
REQ-021 When stall=1, mem_wb_cword SHALL hold its value.
REQ-022 When mem_stall=1 and stall=0, mem_wb_cword SHALL receive a bubble (valid=0, rd_we=0).
REQ-023 dmem_be SHALL be: SB 0001 shifted left by addr[1:0]; SH 0011 shifted left by addr[1:0]; SW 1111.
REQ-024 dmem_wdata SHALL replicate the byte (SB) or halfword (SH) across all lanes.
REQ-025 Loads SHALL select the byte or halfword lane by addr[1:0] and apply funct3 extension: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-026 The extended load value SHALL replace rd_data.
REQ-027 A store SHALL force rd_we=0 in the output cword.
REQ-028 A misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL issue no dmem_req, SHALL pulse misalign_exc for 1 cycle, and SHALL pass the cword with rd_we=0.
REQ-029 A misaligned access SHALL not assert mem_stall.
REQ-030 An access with rd=0 SHALL still perform the memory transaction.

Reset
REQ-031 When rst_n=0 at an edge, the FSM SHALL enter IDLE.
REQ-032 When rst_n=0 at an edge, mem_wb_cword SHALL become all-zero and the load buffer SHALL clear.
REQ-033 Under reset, dmem_req, dmem_we, dmem_be, misalign_exc and mem_stall SHALL be 0.
REQ-034 Reset during BUSY SHALL drop dmem_req at the next edge, with no retry after release.
REQ-035 The first cycle after release SHALL be IDLE.

Structure
REQ-036 rvga_cword, the funct3 load/store encodings and the FSM state enum SHALL reside in the shared rvga_types package.
REQ-037 Lane selection plus sign/zero extension SHALL be a combinational sub-module load_align, reused by any future load path.
REQ-038 No local redefinition of the cword field layout is permitted.

Verification
REQ-039 LW at 0x100 with ack 1 cycle after req and rdata=0xDEADBEEF SHALL give rd_data=0xDEADBEEF, rd_we=1, and mem_stall high for exactly 2 cycles.
REQ-040 LB at 0x103 with rdata=0x80112233 SHALL give rd_data=0xFFFFFF80; LBU at the same address SHALL give 0x00000080.
REQ-041 SH at 0x202 with rs2_data=0x0000ABCD SHALL give dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, and output rd_we=0.
REQ-042 LW at 0x101 SHALL give misalign_exc pulse=1, no dmem_req, mem_stall=0, and output rd_we=0.
REQ-043 Ack held off 5 cycles with stall=1 asserted on the ack cycle for 3 cycles SHALL keep addr/be stable through BUSY, and SHALL keep mem_wb_cword unchanged until stall falls, then emit the load once.
REQ-044 rst_n=0 in the second BUSY cycle SHALL give dmem_req=0 and mem_wb_cword=0 next cycle, and a later ack SHALL be ignored.
